// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core.
// It sequences the shared datapath through fetch, decode, execute, memory
// and writeback steps, and it counts retired instructions.
//
// Memory handshake: mem_read/mem_write together with i_or_d form a request.
// The request stays asserted and unchanged for every cycle in which
// mem_ready is low. The access completes on the rising edge where mem_ready
// is sampled high, and on that same edge the FSM leaves the requesting state.
module multicycle_control #(
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             ext_zero,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // funct is decoded by the ALU control, and zero gates pc_write_cond in the
    // datapath, so neither affects sequencing here.
    logic unused_inputs;
    assign unused_inputs = ^{funct, zero};

    // Next-state and retire decision from the current step and IR opcode.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = S_R_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    // State and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Moore decode of the datapath controls; reset forces every control low
    // in the same cycle so an abandoned instruction writes nothing.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        ext_zero      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_ANDI) begin
                        alu_op   = 2'b11;
                        ext_zero = 1'b1;
                    end
                end
                S_I_WB:     reg_write = 1'b1;
                S_TRAP:     illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed bench for the multicycle control FSM.
// Three instances share one input stream: the default build, a build that
// treats illegal opcodes as NOPs, and a build with a 2-bit retire counter.
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_zero;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        int          cur;
        int          pos;
        int          cls;
        logic [31:0] ret;
    } model_t;

    // ---------------- clock / reset / inputs ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUT outputs, one slot per instance ----------------
    logic        mem_read_o[3], mem_write_o[3], i_or_d_o[3], ir_write_o[3];
    logic        pc_write_o[3], pc_write_cond_o[3], alu_src_a_o[3];
    logic        ext_zero_o[3], reg_dst_o[3], mem_to_reg_o[3], reg_write_o[3];
    logic        illegal_o[3];
    logic [1:0]  pc_source_o[3], alu_src_b_o[3], alu_op_o[3];
    logic [3:0]  state_o[3];
    logic [31:0] retired0, retired1;
    logic [1:0]  retired2;

    multicycle_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_o[0]), .mem_write(mem_write_o[0]),
        .i_or_d(i_or_d_o[0]), .ir_write(ir_write_o[0]), .pc_write(pc_write_o[0]),
        .pc_write_cond(pc_write_cond_o[0]), .pc_source(pc_source_o[0]),
        .alu_src_a(alu_src_a_o[0]), .alu_src_b(alu_src_b_o[0]), .alu_op(alu_op_o[0]),
        .ext_zero(ext_zero_o[0]), .reg_dst(reg_dst_o[0]), .mem_to_reg(mem_to_reg_o[0]),
        .reg_write(reg_write_o[0]), .illegal(illegal_o[0]), .retired(retired0),
        .state(state_o[0])
    );

    multicycle_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_o[1]), .mem_write(mem_write_o[1]),
        .i_or_d(i_or_d_o[1]), .ir_write(ir_write_o[1]), .pc_write(pc_write_o[1]),
        .pc_write_cond(pc_write_cond_o[1]), .pc_source(pc_source_o[1]),
        .alu_src_a(alu_src_a_o[1]), .alu_src_b(alu_src_b_o[1]), .alu_op(alu_op_o[1]),
        .ext_zero(ext_zero_o[1]), .reg_dst(reg_dst_o[1]), .mem_to_reg(mem_to_reg_o[1]),
        .reg_write(reg_write_o[1]), .illegal(illegal_o[1]), .retired(retired1),
        .state(state_o[1])
    );

    multicycle_control #(.CNT_W(2), .TRAP_ON_ILLEGAL(1'b1)) dut_w2 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_o[2]), .mem_write(mem_write_o[2]),
        .i_or_d(i_or_d_o[2]), .ir_write(ir_write_o[2]), .pc_write(pc_write_o[2]),
        .pc_write_cond(pc_write_cond_o[2]), .pc_source(pc_source_o[2]),
        .alu_src_a(alu_src_a_o[2]), .alu_src_b(alu_src_b_o[2]), .alu_op(alu_op_o[2]),
        .ext_zero(ext_zero_o[2]), .reg_dst(reg_dst_o[2]), .mem_to_reg(mem_to_reg_o[2]),
        .reg_write(reg_write_o[2]), .illegal(illegal_o[2]), .retired(retired2),
        .state(state_o[2])
    );

    function automatic ctl_t act_ctl(int i);
        ctl_t c;
        c.mem_read      = mem_read_o[i];
        c.mem_write     = mem_write_o[i];
        c.i_or_d        = i_or_d_o[i];
        c.ir_write      = ir_write_o[i];
        c.pc_write      = pc_write_o[i];
        c.pc_write_cond = pc_write_cond_o[i];
        c.pc_source     = pc_source_o[i];
        c.alu_src_a     = alu_src_a_o[i];
        c.alu_src_b     = alu_src_b_o[i];
        c.alu_op        = alu_op_o[i];
        c.ext_zero      = ext_zero_o[i];
        c.reg_dst       = reg_dst_o[i];
        c.mem_to_reg    = mem_to_reg_o[i];
        c.reg_write     = reg_write_o[i];
        c.illegal       = illegal_o[i];
        return c;
    endfunction

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction class walks a fixed list of steps after DECODE; the
    // instruction retires when its list runs out.
    int routes[7][3] = '{'{6, 7, -1}, '{2, 3, 4}, '{2, 5, -1}, '{8, -1, -1},
                         '{9, -1, -1}, '{10, 11, -1}, '{12, -1, -1}};

    function automatic int cls_of(logic [5:0] op);
        case (op)
            6'h00:        return 0;
            6'h23:        return 1;
            6'h2b:        return 2;
            6'h04:        return 3;
            6'h02:        return 4;
            6'h08, 6'h0c: return 5;
            default:      return 6;
        endcase
    endfunction

    function automatic model_t step_model(model_t m, bit nop_illegal,
                                         logic rst, logic rdy, logic [5:0] op);
        model_t n = m;
        if (rst) begin
            n.cur = 0;
            n.ret = 0;
        end else if (m.cur == 0) begin
            if (rdy) n.cur = 1;
        end else if (m.cur == 12) begin
            n.cur = 12;
        end else if ((m.cur == 3 || m.cur == 5) && !rdy) begin
            n.cur = m.cur;
        end else if (m.cur == 1) begin
            n.cls = cls_of(op);
            if (n.cls == 6 && nop_illegal) begin
                n.ret = m.ret + 1;
                n.cur = 0;
            end else begin
                n.pos = 0;
                n.cur = routes[n.cls][0];
            end
        end else begin
            n.pos = m.pos + 1;
            if (n.pos < 3 && routes[m.cls][n.pos] >= 0) begin
                n.cur = routes[m.cls][n.pos];
            end else begin
                n.ret = m.ret + 1;
                n.cur = 0;
            end
        end
        return n;
    endfunction

    function automatic ctl_t exp_ctl(int cur, logic [5:0] op, logic rdy, logic rst);
        ctl_t o = '0;
        if (rst) return o;
        case (cur)
            0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1: o.alu_src_b = 2'b11;
            2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3: begin o.mem_read = 1; o.i_or_d = 1; end
            4: begin o.mem_to_reg = 1; o.reg_write = 1; end
            5: begin o.mem_write = 1; o.i_or_d = 1; end
            6: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7: begin o.reg_dst = 1; o.reg_write = 1; end
            8: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            9: begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin
                o.alu_src_a = 1;
                o.alu_src_b = 2'b10;
                if (op == 6'h0c) begin o.alu_op = 2'b11; o.ext_zero = 1; end
            end
            11: o.reg_write = 1;
            12: o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    model_t m[2];
    logic   armed = 1'b0;

    // Model advances on the same edge as the DUT.
    always @(posedge clk) begin
        armed <= 1'b1;
        m[0]  <= step_model(m[0], 1'b0, reset, mem_ready, opcode);
        m[1]  <= step_model(m[1], 1'b1, reset, mem_ready, opcode);
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                int mi;
                mi = (i == 1) ? 1 : 0;
                chk($sformatf("cyc_state%0d", i), 32'(state_o[i]), m[mi].cur);
                chk($sformatf("cyc_ctl%0d", i), 32'(act_ctl(i)),
                    32'(exp_ctl(m[mi].cur, opcode, mem_ready, reset)));
            end
            chk("cyc_ret0", retired0, m[0].ret);
            chk("cyc_ret1", retired1, m[1].ret);
            chk("cyc_ret2", 32'(retired2), {30'b0, m[0].ret[1:0]});
        end
    end

    // ---------------- driver and trace recorder ----------------
    int          st_q[$];
    int          st2_q[$];
    ctl_t        ctl_q[$];
    logic [31:0] ret_q[$];
    logic [31:0] ret2_q[$];
    int          exp_st[$];

    task automatic clear_trace();
        st_q.delete(); st2_q.delete(); ctl_q.delete(); ret_q.delete(); ret2_q.delete();
    endtask

    // One clock cycle: drive inputs after the rising edge, sample mid-cycle.
    task automatic cyc(input logic [5:0] op, input logic z, input logic rdy, input logic rst);
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        reset     = rst;
        @(negedge clk);
        st_q.push_back(int'(state_o[0]));
        st2_q.push_back(int'(state_o[1]));
        ctl_q.push_back(act_ctl(0));
        ret_q.push_back(retired0);
        ret2_q.push_back(retired1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, st_q.size(), exp_st.size());
        for (int i = 0; i < exp_st.size() && i < st_q.size(); i++)
            chk($sformatf("%s_st%0d", name, i), st_q[i], exp_st[i]);
    endtask

    function automatic int count_pc_write();
        int n = 0;
        foreach (ctl_q[i]) n += int'(ctl_q[i].pc_write);
        return n;
    endfunction

    function automatic int count_reg_write();
        int n = 0;
        foreach (ctl_q[i]) n += int'(ctl_q[i].reg_write);
        return n;
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        // Reset for two cycles; controls forced low even though state is FETCH.
        clear_trace();
        cyc(6'h00, 0, 1, 1);
        cyc(6'h00, 0, 1, 1);
        chk("rst_state", st_q[1], 0);
        chk("rst_ret", ret_q[1], 0);
        chk("rst_ctl", 32'(ctl_q[1]), 0);

        // add with memory always ready; trailing FETCH stalls to keep alignment.
        clear_trace();
        repeat (4) cyc(6'h00, 0, 1, 0);
        cyc(6'h00, 0, 0, 0);
        exp_st = {0, 1, 6, 7, 0};
        chk_seq("add");
        chk("add_ret", ret_q[4], 1);
        chk("add_regw_cnt", count_reg_write(), 1);
        chk("add_reg_dst", ctl_q[3].reg_dst, 1);

        // lw with 3 fetch wait cycles and 2 read wait cycles.
        clear_trace();
        foreach (exp_st[i]) ; // keep queue type in use
        cyc(6'h23, 0, 0, 0); cyc(6'h23, 0, 0, 0); cyc(6'h23, 0, 0, 0);
        cyc(6'h23, 0, 1, 0); cyc(6'h23, 0, 1, 0); cyc(6'h23, 0, 1, 0);
        cyc(6'h23, 0, 0, 0); cyc(6'h23, 0, 0, 0); cyc(6'h23, 0, 1, 0);
        cyc(6'h23, 0, 1, 0); cyc(6'h23, 0, 0, 0);
        exp_st = {0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
        chk_seq("lw");
        chk("lw_pc_write_cnt", count_pc_write(), 1);
        chk("lw_mem_to_reg", ctl_q[9].mem_to_reg, 1);
        for (int i = 6; i < 9; i++)
            chk($sformatf("lw_req%0d", i), {ctl_q[i].mem_read, ctl_q[i].i_or_d}, 2'b11);
        chk("lw_ret", ret_q[10], 2);

        // sw with a 2-cycle write stall, then a taken beq.
        clear_trace();
        cyc(6'h2b, 0, 1, 0); cyc(6'h2b, 0, 1, 0); cyc(6'h2b, 0, 1, 0);
        cyc(6'h2b, 0, 0, 0); cyc(6'h2b, 0, 0, 0); cyc(6'h2b, 0, 1, 0);
        cyc(6'h04, 1, 1, 0); cyc(6'h04, 1, 1, 0); cyc(6'h04, 1, 1, 0);
        cyc(6'h04, 1, 0, 0);
        exp_st = {0, 1, 2, 5, 5, 5, 0, 1, 8, 0};
        chk_seq("swbeq");
        for (int i = 3; i < 6; i++)
            chk($sformatf("sw_req%0d", i), {ctl_q[i].mem_write, ctl_q[i].i_or_d}, 2'b11);
        chk("beq_pwc", ctl_q[8].pc_write_cond, 1);
        chk("beq_pc_source", ctl_q[8].pc_source, 2'b01);
        chk("beq_alu_op", ctl_q[8].alu_op, 2'b01);
        chk("swbeq_ret", ret_q[9], 4);

        // andi, addi, j.
        clear_trace();
        repeat (4) cyc(6'h0c, 0, 1, 0);
        repeat (4) cyc(6'h08, 0, 1, 0);
        repeat (3) cyc(6'h02, 0, 1, 0);
        cyc(6'h02, 0, 0, 0);
        exp_st = {0, 1, 10, 11, 0, 1, 10, 11, 0, 1, 9, 0};
        chk_seq("imm");
        chk("andi_ext", {ctl_q[2].ext_zero, ctl_q[2].alu_op}, 3'b111);
        chk("addi_ext", {ctl_q[6].ext_zero, ctl_q[6].alu_op}, 3'b000);
        chk("andi_wb", {ctl_q[3].reg_dst, ctl_q[3].reg_write}, 2'b01);
        chk("addi_wb", {ctl_q[7].reg_dst, ctl_q[7].reg_write}, 2'b01);
        chk("j_pc", {ctl_q[10].pc_write, ctl_q[10].pc_source}, 3'b110);
        chk("imm_ret", ret_q[11], 7);

        // Illegal opcode: trap held for 20 cycles, NOP build retires instead.
        clear_trace();
        repeat (22) cyc(6'h3f, 0, 1, 0);
        for (int i = 2; i < 22; i++)
            chk($sformatf("trap%0d", i), {st_q[i], ctl_q[i].illegal}, {32'd12, 1'b1});
        chk("nop_state", st2_q[2], 0);
        chk("nop_ret", ret2_q[2], 8);
        cyc(6'h3f, 0, 1, 1);
        chk("trap_rst_illegal", ctl_q[22].illegal, 0);
        cyc(6'h00, 0, 0, 0);
        chk("trap_rst_state", st_q[23], 0);
        chk("trap_rst_ret", ret_q[23], 0);

        // Reset in the middle of a stalled store.
        clear_trace();
        repeat (4) cyc(6'h00, 0, 1, 0);
        cyc(6'h2b, 0, 1, 0); cyc(6'h2b, 0, 1, 0); cyc(6'h2b, 0, 1, 0);
        cyc(6'h2b, 0, 0, 0);
        cyc(6'h2b, 0, 0, 1);
        cyc(6'h2b, 0, 0, 0);
        exp_st = {0, 1, 6, 7, 0, 1, 2, 5, 5, 0};
        chk_seq("abort");
        chk("abort_pre_ret", ret_q[4], 1);
        chk("abort_ctl", 32'(ctl_q[8]), 0);
        chk("abort_ret", ret_q[9], 0);
        chk("abort_regw", ctl_q[8].reg_write | ctl_q[9].reg_write, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
